// File: rtl/seg7_capture.sv
// Observer for a multiplexed active-low 7-segment bus: samples settled digits,
// checks the ones->tens->hundreds->thousands frame and reports the two-digit count.
//   state     | meaning
//   WAIT_ONES | idle, looking for a settled ones digit
//   GOT_ONES  | ones latched, expecting tens BCD
//   GOT_TENS  | tens latched, expecting hundreds DASH
//   GOT_HUND  | hundreds DASH seen, expecting thousands DASH
module seg7_capture #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 250_000
) (
  input  logic       clk_50MHz,
  input  logic       reset_n,
  input  logic [7:0] seg,
  input  logic [3:0] digit,
  output logic [7:0] count,
  output logic       count_valid,
  output logic       decode_err,
  output logic       stale
);

  typedef enum logic [1:0] {WAIT_ONES, GOT_ONES, GOT_TENS, GOT_HUND} state_t;

  localparam logic [3:0]  V_DASH  = 4'd10;
  localparam logic [3:0]  V_BAD   = 4'd15;
  localparam logic [7:0]  FIRE_AT = 8'(SETTLE_CYCLES - 2);
  localparam logic [17:0] T_MAX   = 18'(TIMEOUT_CYCLES - 1);

  logic [7:0]  r_seg_s1, r_seg_s2, r_seg_prev;
  logic [3:0]  r_dig_s1, r_dig_s2, r_dig_prev;
  logic [7:0]  r_stab;
  state_t      r_state, w_state_nxt;
  logic [3:0]  r_ones, r_tens;
  logic [7:0]  r_count;
  logic        r_count_valid, r_decode_err, r_stale;
  logic [17:0] r_timer;

  logic        w_onehot, w_changed, w_sample;
  logic [3:0]  w_val;
  logic        w_is_bcd, w_is_dash;
  logic        w_ld_ones, w_ld_tens, w_done, w_err;

  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_seg_s1   <= '0;
      r_seg_s2   <= '0;
      r_seg_prev <= '0;
      r_dig_s1   <= '0;
      r_dig_s2   <= '0;
      r_dig_prev <= '0;
      r_stab     <= '0;
    end else begin
      r_seg_s1   <= seg;
      r_seg_s2   <= r_seg_s1;
      r_seg_prev <= r_seg_s2;
      r_dig_s1   <= digit;
      r_dig_s2   <= r_dig_s1;
      r_dig_prev <= r_dig_s2;
      if (!w_onehot || w_changed)
        r_stab <= '0;
      else if (r_stab != 8'hFF)
        r_stab <= r_stab + 8'd1;
    end
  end

  assign w_onehot  = (r_dig_s2 != 4'd0) && ((r_dig_s2 & (r_dig_s2 - 4'd1)) == 4'd0);
  assign w_changed = {r_dig_s2, r_seg_s2} != {r_dig_prev, r_seg_prev};
  // r_stab==0 on the first unchanged cycle, so SETTLE-2 marks SETTLE cycles of s2 dwell.
  assign w_sample  = w_onehot && !w_changed && (r_stab == FIRE_AT);

  always_comb begin
    w_val = V_BAD;
    case (r_seg_s2)
      8'h03: w_val = 4'd0;
      8'h9F: w_val = 4'd1;
      8'h25: w_val = 4'd2;
      8'h0D: w_val = 4'd3;
      8'h99: w_val = 4'd4;
      8'h49: w_val = 4'd5;
      8'h41: w_val = 4'd6;
      8'h1F: w_val = 4'd7;
      8'h01: w_val = 4'd8;
      8'h09: w_val = 4'd9;
      8'hFD: w_val = V_DASH;
      default: w_val = V_BAD;
    endcase
  end

  assign w_is_bcd  = (w_val <= 4'd9);
  assign w_is_dash = (w_val == V_DASH);

  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) r_state <= WAIT_ONES;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ld_ones   = 1'b0;
    w_ld_tens   = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    if (w_sample) begin
      case (r_state)
        WAIT_ONES: begin
          if (r_dig_s2 == 4'b0001) begin
            if (w_is_bcd) begin
              w_ld_ones   = 1'b1;
              w_state_nxt = GOT_ONES;
            end else begin
              w_err = 1'b1;
            end
          end
        end
        GOT_ONES: begin
          if (r_dig_s2 == 4'b0010 && w_is_bcd) begin
            w_ld_tens   = 1'b1;
            w_state_nxt = GOT_TENS;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = WAIT_ONES;
          end
        end
        GOT_TENS: begin
          if (r_dig_s2 == 4'b0100 && w_is_dash) begin
            w_state_nxt = GOT_HUND;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = WAIT_ONES;
          end
        end
        GOT_HUND: begin
          if (r_dig_s2 == 4'b1000 && w_is_dash) w_done = 1'b1;
          else                                  w_err  = 1'b1;
          w_state_nxt = WAIT_ONES;
        end
        default: w_state_nxt = WAIT_ONES;
      endcase
    end
  end

  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_ones        <= '0;
      r_tens        <= '0;
      r_count       <= '0;
      r_count_valid <= 1'b0;
      r_decode_err  <= 1'b0;
      r_timer       <= '0;
      r_stale       <= 1'b0;
    end else begin
      r_count_valid <= w_done;
      r_decode_err  <= w_err;
      if (w_ld_ones) r_ones <= w_val;
      if (w_ld_tens) r_tens <= w_val;
      if (w_done)    r_count <= {r_tens, r_ones};
      // A completed frame beats timer saturation.
      if (w_done) begin
        r_timer <= '0;
        r_stale <= 1'b0;
      end else if (r_timer == T_MAX) begin
        r_stale <= 1'b1;
      end else begin
        r_timer <= r_timer + 18'd1;
      end
    end
  end

  assign count       = r_count;
  assign count_valid = r_count_valid;
  assign decode_err  = r_decode_err;
  assign stale       = r_stale;

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: table of whole frames plus hand-written corner sequences,
// with a scoreboard queue matched against count_valid/decode_err pulses.
module tb_seg7_capture;

  localparam int SETTLE = 16;
  localparam int TMO    = 3000;
  localparam int DWELL  = 200;

  logic       clk_50MHz = 1'b0;
  logic       reset_n;
  logic [7:0] seg;
  logic [3:0] digit;
  logic [7:0] count;
  logic       count_valid, decode_err, stale;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       is_err;
    logic [7:0] cnt;
  } ev_t;

  typedef struct {
    logic [7:0] s_ones, s_tens, s_hund, s_thou;
    logic       exp_err;
    logic [7:0] exp_cnt;
  } vec_t;

  ev_t        sb_q[$];
  ev_t        mon_e;
  vec_t       vecs[10];
  logic [7:0] last_cnt;
  int         n;

  seg7_capture #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_50MHz  (clk_50MHz),
    .reset_n    (reset_n),
    .seg        (seg),
    .digit      (digit),
    .count      (count),
    .count_valid(count_valid),
    .decode_err (decode_err),
    .stale      (stale)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h", nm, got, exp);
    end
  endtask

  task automatic push_ev(input logic e, input logic [7:0] c);
    ev_t ev;
    ev.is_err = e;
    ev.cnt    = c;
    sb_q.push_back(ev);
  endtask

  task automatic hold(input logic [3:0] d, input logic [7:0] s, input int cyc);
    digit = d;
    seg   = s;
    repeat (cyc) @(posedge clk_50MHz);
    #1;
  endtask

  task automatic frame(input logic [7:0] s0, input logic [7:0] s1,
                       input logic [7:0] s2, input logic [7:0] s3);
    hold(4'b0001, s0, DWELL);
    hold(4'b0010, s1, DWELL);
    hold(4'b0100, s2, DWELL);
    hold(4'b1000, s3, DWELL);
  endtask

  always @(negedge clk_50MHz) begin
    if (reset_n === 1'b1) begin
      if (count_valid && decode_err) begin
        total++;
        bad++;
        $display("FAIL exclusive cv=%0b err=%0b required not both high", count_valid, decode_err);
      end else if (count_valid || decode_err) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event cv=%0b err=%0b count=%h required no event",
                   count_valid, decode_err, count);
        end else begin
          mon_e = sb_q.pop_front();
          if (mon_e.is_err !== decode_err || (!mon_e.is_err && count !== mon_e.cnt)) begin
            bad++;
            $display("FAIL event got err=%0b count=%h required err=%0b count=%h",
                     decode_err, count, mon_e.is_err, mon_e.cnt);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d required completion", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h1F, 8'h99, 8'hFD, 8'hFD, 1'b0, 8'h47};
    vecs[1] = '{8'h03, 8'h25, 8'hFD, 8'hFD, 1'b0, 8'h20};
    vecs[2] = '{8'h01, 8'h09, 8'hFD, 8'hFD, 1'b0, 8'h98};
    vecs[3] = '{8'h1F, 8'h99, 8'hFD, 8'hFD, 1'b0, 8'h47};
    vecs[4] = '{8'h9F, 8'hFF, 8'hFD, 8'hFD, 1'b1, 8'h00};
    vecs[5] = '{8'h41, 8'h0D, 8'hFD, 8'hFD, 1'b0, 8'h36};
    vecs[6] = '{8'hFD, 8'h0D, 8'hFD, 8'hFD, 1'b1, 8'h00};
    vecs[7] = '{8'h49, 8'h99, 8'h49, 8'hFD, 1'b1, 8'h00};
    vecs[8] = '{8'h99, 8'h49, 8'hFD, 8'h03, 1'b1, 8'h00};
    vecs[9] = '{8'h0D, 8'h9F, 8'hFD, 8'hFD, 1'b0, 8'h13};

    reset_n = 1'b0;
    seg     = 8'hFF;
    digit   = 4'b0000;
    repeat (3) @(posedge clk_50MHz);
    #1;
    check("rst_count", 32'(count), 32'h00);
    check("rst_cv", 32'(count_valid), 32'h0);
    check("rst_err", 32'(decode_err), 32'h0);
    check("rst_stale", 32'(stale), 32'h0);
    reset_n = 1'b1;
    hold(4'b0000, 8'hFF, 5);

    last_cnt = 8'h00;
    for (int i = 0; i < 10; i++) begin
      push_ev(vecs[i].exp_err, vecs[i].exp_cnt);
      frame(vecs[i].s_ones, vecs[i].s_tens, vecs[i].s_hund, vecs[i].s_thou);
      if (!vecs[i].exp_err) last_cnt = vecs[i].exp_cnt;
      check($sformatf("vec%0d_count", i), 32'(count), 32'(last_cnt));
      check($sformatf("vec%0d_drained", i), 32'(sb_q.size()), 32'd0);
    end

    // Latency: thousands DASH driven in cycle c, pulse expected in c+18.
    hold(4'b0001, 8'h1F, DWELL);
    hold(4'b0010, 8'h99, DWELL);
    hold(4'b0100, 8'hFD, DWELL);
    push_ev(1'b0, 8'h47);
    digit = 4'b1000;
    seg   = 8'hFD;
    n = 0;
    while (count_valid !== 1'b1 && n < 60) begin
      @(posedge clk_50MHz);
      #1;
      n++;
    end
    check("latency", 32'(n), 32'd18);
    check("latency_count", 32'(count), 32'h47);
    hold(4'b1000, 8'hFD, DWELL);
    check("latency_drained", 32'(sb_q.size()), 32'd0);

    // Glitch: short tens dwell must never be sampled.
    hold(4'b0001, 8'h9F, DWELL);
    hold(4'b0010, 8'h0D, 10);
    hold(4'b0010, 8'h25, DWELL);
    hold(4'b0100, 8'hFD, DWELL);
    push_ev(1'b0, 8'h21);
    hold(4'b1000, 8'hFD, DWELL);
    check("glitch_count", 32'(count), 32'h21);
    check("glitch_stale", 32'(stale), 32'h0);
    check("glitch_drained", 32'(sb_q.size()), 32'd0);

    // Out of order, then non-one-hot select; tail frame must be ignored from WAIT_ONES.
    hold(4'b0001, 8'h03, DWELL);
    push_ev(1'b1, 8'h00);
    hold(4'b0100, 8'hFD, DWELL);
    check("ooo_err_seen", 32'(sb_q.size()), 32'd0);
    hold(4'b0011, 8'hFD, 500);
    hold(4'b0010, 8'h99, DWELL);
    hold(4'b0100, 8'hFD, DWELL);
    hold(4'b1000, 8'hFD, DWELL);
    check("ooo_count", 32'(count), 32'h21);

    // Stale after a long idle, then reset mid-frame clears everything.
    hold(4'b0000, 8'hFF, TMO + 20);
    check("stale_set", 32'(stale), 32'h1);
    hold(4'b0001, 8'h41, DWELL);
    hold(4'b0010, 8'h0D, 100);
    #3;
    reset_n = 1'b0;
    #1;
    check("midrst_count", 32'(count), 32'h00);
    check("midrst_cv", 32'(count_valid), 32'h0);
    check("midrst_err", 32'(decode_err), 32'h0);
    check("midrst_stale", 32'(stale), 32'h0);
    repeat (3) @(posedge clk_50MHz);
    #1;
    reset_n = 1'b1;
    push_ev(1'b0, 8'h36);
    frame(8'h41, 8'h0D, 8'hFD, 8'hFD);
    check("post_rst_count", 32'(count), 32'h36);
    check("post_rst_stale", 32'(stale), 32'h0);
    check("post_rst_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
